// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, perf-counter width, ALU source selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_detect_unit_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Encodings are architecturally visible on HazState; code 3 is never entered deliberately.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_BR_FLUSH = 2'd2,
        HZ_UNUSED   = 2'd3
    } haz_state_t;

    // ALU operand-B source select used by the EX stage.
    typedef enum logic [1:0] {
        ALU_SRC_REG   = 2'd0,
        ALU_SRC_IMM   = 2'd1,
        ALU_SRC_SHAMT = 2'd2,
        ALU_SRC_PC4   = 2'd3
    } alu_src_t;

endpackage

// File: rtl/hazard_detect_unit_sat_counter.sv
// Saturating 16-bit event counter with synchronous clear (clear beats increment).
// Latency: q updates on the clock edge after inc/clr; async active-high reset to 0.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst, clr (sync clear), inc (count enable), q (count value).
module sat_counter_16
    import hazard_detect_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Pipeline hazard unit: load-use stall, branch/jump flush, external freeze, perf counters.
// Latency: write-enable/flush outputs are combinational (zero cycle); HazState and counters registered.
// Backpressure: Stall_Req freezes PC and IF/ID and holds the FSM until released.
// Ports: IF/ID sources (Rs/Rt/UsesRt), ID/EX dest + MemRead, Jump_ID, BranchTaken_Ex_Mem,
//        Stall_Req, Cnt_Clr in; PCWr, IF_ID_Wr, three flushes, HazState, three 16-bit counters out.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             UsesRt_IF_ID,
    input  logic [4:0]       RegTarget_ID_EX,
    input  logic             MemRead_ID_EX,
    input  logic             Jump_ID,
    input  logic             BranchTaken_Ex_Mem,
    input  logic             Stall_Req,
    input  logic             Cnt_Clr,
    output logic             PCWr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Ex_Mem_Flush,
    output logic [1:0]       HazState,
    output logic [CNT_W-1:0] LoadStall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Freeze_Cnt
);

    haz_state_t state;
    haz_state_t state_nxt;
    logic       load_use;
    logic       inc_ls;
    logic       inc_fl;
    logic       inc_fz;

    // $0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = MemRead_ID_EX && (RegTarget_ID_EX != 5'd0) &&
                      ((RegTarget_ID_EX == Rs_IF_ID) ||
                       (UsesRt_IF_ID && (RegTarget_ID_EX == Rt_IF_ID)));

    // Priority chain: freeze > taken branch > jump > load-use > normal flow.
    // Every non-frozen cycle returns to RUN unless a new event sets otherwise,
    // which makes LU_STALL/BR_FLUSH last exactly one unfrozen cycle.
    always_comb begin
        PCWr         = 1'b1;
        IF_ID_Wr     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Ex_Mem_Flush = 1'b0;
        state_nxt    = HZ_RUN;
        inc_ls       = 1'b0;
        inc_fl       = 1'b0;
        inc_fz       = 1'b0;
        if (Stall_Req) begin
            PCWr      = 1'b0;
            IF_ID_Wr  = 1'b0;
            state_nxt = (state == HZ_UNUSED) ? HZ_RUN : state;
            inc_fz    = 1'b1;
        end else if (BranchTaken_Ex_Mem) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            Ex_Mem_Flush = 1'b1;
            state_nxt    = HZ_BR_FLUSH;
            inc_fl       = 1'b1;
        end else if (Jump_ID) begin
            IF_ID_Flush = 1'b1;
            inc_fl      = 1'b1;
        end else if (load_use && (state == HZ_RUN)) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            PCWr        = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EX_Flush = 1'b1;
            state_nxt   = HZ_LU_STALL;
            inc_ls      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign HazState = state;

    sat_counter_16 u_ls_cnt (
        .clk (clk),
        .rst (rst),
        .clr (Cnt_Clr),
        .inc (inc_ls),
        .q   (LoadStall_Cnt)
    );

    sat_counter_16 u_fl_cnt (
        .clk (clk),
        .rst (rst),
        .clr (Cnt_Clr),
        .inc (inc_fl),
        .q   (Flush_Cnt)
    );

    sat_counter_16 u_fz_cnt (
        .clk (clk),
        .rst (rst),
        .clr (Cnt_Clr),
        .inc (inc_fz),
        .q   (Freeze_Cnt)
    );

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed scenarios plus randomized traffic
// compared against an event-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_detect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs_IF_ID, Rt_IF_ID, RegTarget_ID_EX;
    logic        UsesRt_IF_ID, MemRead_ID_EX, Jump_ID, BranchTaken_Ex_Mem, Stall_Req, Cnt_Clr;
    logic        PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Ex_Mem_Flush;
    logic [1:0]  HazState;
    logic [15:0] LoadStall_Cnt, Flush_Cnt, Freeze_Cnt;
    logic [6:0]  obs;

    int checks = 0;
    int errors = 0;

    // Reference model state: visible FSM state and counter values.
    int m_state = 0;
    int m_ls = 0;
    int m_fl = 0;
    int m_fz = 0;

    always #5 clk = ~clk;

    hazard_detect_unit dut (
        .clk                (clk),
        .rst                (rst),
        .Rs_IF_ID           (Rs_IF_ID),
        .Rt_IF_ID           (Rt_IF_ID),
        .UsesRt_IF_ID       (UsesRt_IF_ID),
        .RegTarget_ID_EX    (RegTarget_ID_EX),
        .MemRead_ID_EX      (MemRead_ID_EX),
        .Jump_ID            (Jump_ID),
        .BranchTaken_Ex_Mem (BranchTaken_Ex_Mem),
        .Stall_Req          (Stall_Req),
        .Cnt_Clr            (Cnt_Clr),
        .PCWr               (PCWr),
        .IF_ID_Wr           (IF_ID_Wr),
        .IF_ID_Flush        (IF_ID_Flush),
        .ID_EX_Flush        (ID_EX_Flush),
        .Ex_Mem_Flush       (Ex_Mem_Flush),
        .HazState           (HazState),
        .LoadStall_Cnt      (LoadStall_Cnt),
        .Flush_Cnt          (Flush_Cnt),
        .Freeze_Cnt         (Freeze_Cnt)
    );

    assign obs = {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Ex_Mem_Flush, HazState};

    // ---------------- reference model ----------------
    function automatic logic is_lu();
        return MemRead_ID_EX && (RegTarget_ID_EX != 5'd0) &&
               ((RegTarget_ID_EX == Rs_IF_ID) || (UsesRt_IF_ID && (RegTarget_ID_EX == Rt_IF_ID)));
    endfunction

    // {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, Ex_Mem_Flush, HazState}
    function automatic logic [6:0] exp_out();
        logic [1:0] st;
        st = 2'(m_state);
        if (Stall_Req)          return {5'b00000, st};
        if (BranchTaken_Ex_Mem) return {5'b11111, st};
        if (Jump_ID)            return {5'b11100, st};
        if (is_lu() && m_state == 0) return {5'b00010, st};
        return {5'b11000, st};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ls = 0;
        m_fl = 0;
        m_fz = 0;
    endtask

    // Advance one clock and update the model from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (Stall_Req) begin
                m_fz = sat_inc(m_fz);
            end else if (BranchTaken_Ex_Mem) begin
                m_fl = sat_inc(m_fl);
                m_state = 2;
            end else if (Jump_ID) begin
                m_fl = sat_inc(m_fl);
                m_state = 0;
            end else if (is_lu() && m_state == 0) begin
                m_ls = sat_inc(m_ls);
                m_state = 1;
            end else begin
                m_state = 0;
            end
            if (Cnt_Clr) begin
                m_ls = 0;
                m_fl = 0;
                m_fz = 0;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                          input logic [4:0] tgt, input logic mr, input logic j,
                          input logic br, input logic sr, input logic clr);
        Rs_IF_ID = rs;
        Rt_IF_ID = rt;
        UsesRt_IF_ID = ut;
        RegTarget_ID_EX = tgt;
        MemRead_ID_EX = mr;
        Jump_ID = j;
        BranchTaken_Ex_Mem = br;
        Stall_Req = sr;
        Cnt_Clr = clr;
    endtask

    task automatic idle();
        set_in(5'd1, 5'd3, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // lw $2 in ID/EX, add $3,$2,$4 in IF/ID
    task automatic lu_in(input logic j, input logic br, input logic sr, input logic clr);
        set_in(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, j, br, sr, clr);
    endtask

    task automatic clear_counters();
        @(negedge clk);
        set_in(5'd1, 5'd3, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1;
        checks++;
        if (HazState !== 2'd0 || LoadStall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0 || Freeze_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%h/%h/%h required 0 and 0/0/0",
                     HazState, LoadStall_Cnt, Flush_Cnt, Freeze_Cnt);
        end
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_outputs_idle: got %b required %b", obs, 7'b1100000);
        end
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_outputs_lu: got %b required %b", obs, 7'b0001000);
        end
        tick();
        checks++;
        if (HazState !== 2'd0 || LoadStall_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_holds: state=%0d ls=%h required 0 and 0", HazState, LoadStall_Cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL lu_stall_outputs: got %b required %b", obs, 7'b0001000);
        end
        tick();
        checks++;
        if (HazState !== 2'd1 || LoadStall_Cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_enter: state=%0d ls=%0d required 1 and 1", HazState, LoadStall_Cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== 7'b1100001) begin
            errors++;
            $display("FAIL lu_suppressed: got %b required %b", obs, 7'b1100001);
        end
        tick();
        checks++;
        if (HazState !== 2'd0 || LoadStall_Cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_exit: state=%0d ls=%0d required 0 and 1", HazState, LoadStall_Cnt);
        end
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        set_in(5'd0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL no_stall_r0: got %b required %b", obs, 7'b1100000);
        end
        tick();
        @(negedge clk);
        set_in(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL no_stall_rt_unused: got %b required %b", obs, 7'b1100000);
        end
        tick();
        checks++;
        if (LoadStall_Cnt !== 16'd1 || HazState !== 2'd0) begin
            errors++;
            $display("FAIL no_stall_counts: ls=%0d state=%0d required 1 and 0", LoadStall_Cnt, HazState);
        end
        @(negedge clk);
        set_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL stall_via_rt: got %b required %b", obs, 7'b0001000);
        end
        tick();
        @(negedge clk);
        idle();
        tick();
        checks++;
        if (LoadStall_Cnt !== 16'd2 || HazState !== 2'd0) begin
            errors++;
            $display("FAIL stall_via_rt_counts: ls=%0d state=%0d required 2 and 0", LoadStall_Cnt, HazState);
        end
    endtask

    task automatic test_branch_over_lu();
        clear_counters();
        @(negedge clk);
        lu_in(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1111100) begin
            errors++;
            $display("FAIL branch_outputs: got %b required %b", obs, 7'b1111100);
        end
        tick();
        checks++;
        if (HazState !== 2'd2 || Flush_Cnt !== 16'd1 || LoadStall_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL branch_enter: state=%0d fl=%0d ls=%0d required 2,1,0",
                     HazState, Flush_Cnt, LoadStall_Cnt);
        end
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1100010) begin
            errors++;
            $display("FAIL br_flush_lu_suppressed: got %b required %b", obs, 7'b1100010);
        end
        tick();
        checks++;
        if (HazState !== 2'd0 || LoadStall_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL br_flush_exit: state=%0d ls=%0d required 0 and 0", HazState, LoadStall_Cnt);
        end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_jump();
        clear_counters();
        @(negedge clk);
        lu_in(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1110000) begin
            errors++;
            $display("FAIL jump_outputs: got %b required %b", obs, 7'b1110000);
        end
        tick();
        checks++;
        if (HazState !== 2'd0 || Flush_Cnt !== 16'd1 || LoadStall_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL jump_counts: state=%0d fl=%0d ls=%0d required 0,1,0", HazState, Flush_Cnt, LoadStall_Cnt);
        end
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        lu_in(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b1110001) begin
            errors++;
            $display("FAIL jump_in_lu_stall: got %b required %b", obs, 7'b1110001);
        end
        tick();
        checks++;
        if (HazState !== 2'd0 || Flush_Cnt !== 16'd2 || LoadStall_Cnt !== 16'd1) begin
            errors++;
            $display("FAIL jump_in_lu_stall_counts: state=%0d fl=%0d ls=%0d required 0,2,1",
                     HazState, Flush_Cnt, LoadStall_Cnt);
        end
    endtask

    task automatic test_freeze_during_lu();
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lu_in(1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("FAIL freeze_outputs[%0d]: got %b required %b", i, obs, 7'b0000000);
            end
            tick();
            checks++;
            if (Freeze_Cnt !== 16'(i + 1) || HazState !== 2'd0 || LoadStall_Cnt !== 16'd0) begin
                errors++;
                $display("FAIL freeze_count[%0d]: fz=%0d state=%0d ls=%0d required %0d,0,0",
                         i, Freeze_Cnt, HazState, LoadStall_Cnt, i + 1);
            end
        end
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL freeze_release_stall: got %b required %b", obs, 7'b0001000);
        end
        tick();
        checks++;
        if (HazState !== 2'd1 || LoadStall_Cnt !== 16'd1 || Freeze_Cnt !== 16'd3) begin
            errors++;
            $display("FAIL freeze_release_counts: state=%0d ls=%0d fz=%0d required 1,1,3",
                     HazState, LoadStall_Cnt, Freeze_Cnt);
        end
        // Freezing inside LU_STALL must hold the state until an unfrozen cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            lu_in(1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            checks++;
            if (HazState !== 2'd1) begin
                errors++;
                $display("FAIL freeze_holds_lu_stall[%0d]: state=%0d required 1", i, HazState);
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (obs !== 7'b1100001) begin
            errors++;
            $display("FAIL lu_stall_after_freeze: got %b required %b", obs, 7'b1100001);
        end
        tick();
        checks++;
        if (HazState !== 2'd0) begin
            errors++;
            $display("FAIL lu_stall_exit_after_freeze: state=%0d required 0", HazState);
        end
    endtask

    task automatic test_clear_wins();
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL clr_outputs: got %b required %b", obs, 7'b0001000);
        end
        tick();
        checks++;
        if (LoadStall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0 || Freeze_Cnt !== 16'd0 || HazState !== 2'd1) begin
            errors++;
            $display("FAIL clr_wins: cnt=%h/%h/%h state=%0d required 0/0/0 and 1",
                     LoadStall_Cnt, Flush_Cnt, Freeze_Cnt, HazState);
        end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_reset_midstall();
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (HazState !== 2'd0 || LoadStall_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_lu_stall: state=%0d ls=%0d required 0 and 0", HazState, LoadStall_Cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        lu_in(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== 7'b0001000) begin
            errors++;
            $display("FAIL after_rst_run: got %b required %b", obs, 7'b0001000);
        end
        tick();
        @(negedge clk);
        lu_in(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (HazState !== 2'd0 || Flush_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_br_flush: state=%0d fl=%0d required 0 and 0", HazState, Flush_Cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            #1;
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: got %b required %b", i, obs, exp_out());
            end
            tick();
            checks++;
            if (HazState !== 2'(m_state) || LoadStall_Cnt !== 16'(m_ls) ||
                Flush_Cnt !== 16'(m_fl) || Freeze_Cnt !== 16'(m_fz)) begin
                errors++;
                $display("FAIL rand_state[%0d]: state=%0d cnt=%0d/%0d/%0d required %0d and %0d/%0d/%0d",
                         i, HazState, LoadStall_Cnt, Flush_Cnt, Freeze_Cnt, m_state, m_ls, m_fl, m_fz);
            end
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65534) tick();
        checks++;
        if (Freeze_Cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: fz=%h required fffe", Freeze_Cnt);
        end
        repeat (3) tick();
        checks++;
        if (Freeze_Cnt !== 16'hFFFF || LoadStall_Cnt !== 16'd0 || Flush_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_hold: fz=%h ls=%h fl=%h required ffff,0,0", Freeze_Cnt, LoadStall_Cnt, Flush_Cnt);
        end
        @(negedge clk);
        lu_in(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if (Freeze_Cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear: fz=%h required 0", Freeze_Cnt);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_over_lu();
        test_jump();
        test_freeze_during_lu();
        test_clear_wins();
        test_reset_midstall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  pipeline clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 Rs_IF_ID, Rt_IF_ID  in  5 each  source register numbers of the instruction in the IF/ID register.
REQ-005 UsesRt_IF_ID  in  1  IF/ID instruction reads Rt as a source (R-type, beq, sw).
REQ-006 RegTarget_ID_EX  in  5  destination register number in ID/EX.
REQ-007 MemRead_ID_EX  in  1  ID/EX instruction is a load.
REQ-008 Jump_ID  in  1  jump decoded in ID.
REQ-009 BranchTaken_Ex_Mem  in  1  branch resolved taken in EX/MEM.
REQ-010 Stall_Req  in  1  external freeze request (memory not ready).
REQ-011 Cnt_Clr  in  1  synchronous clear of all counters.
REQ-012 PCWr, IF_ID_Wr  out  1 each  PC / IF-ID register write enables.
REQ-013 IF_ID_Flush, ID_EX_Flush, Ex_Mem_Flush  out  1 each  bubble-insert controls.
REQ-014 HazState  out  2  current FSM state.
REQ-015 LoadStall_Cnt, Flush_Cnt, Freeze_Cnt  out  16 each  saturating performance counters.

Function
REQ-016 Load-use hazard (LU) SHALL be: MemRead_ID_EX=1, RegTarget_ID_EX!=0, and (RegTarget_ID_EX==Rs_IF_ID or (UsesRt_IF_ID=1 and RegTarget_ID_EX==Rt_IF_ID)).
REQ-017 Hazard outputs SHALL be combinational from inputs and state (zero-cycle latency).
REQ-018 Priority, highest first: Stall_Req, BranchTaken_Ex_Mem, Jump_ID, LU, none.
REQ-019 Stall_Req=1: PCWr=0, IF_ID_Wr=0, all flushes 0, state held, only Freeze_Cnt increments.
REQ-020 BranchTaken_Ex_Mem=1: PCWr=1, IF_ID_Wr=1, IF_ID_Flush=ID_EX_Flush=Ex_Mem_Flush=1; next state BR_FLUSH; Flush_Cnt +1.
REQ-021 Jump_ID=1 (no branch): PCWr=1, IF_ID_Wr=1, IF_ID_Flush=1 only; state unchanged; Flush_Cnt +1.
REQ-022 LU in state RUN: PCWr=0, IF_ID_Wr=0, ID_EX_Flush=1 (one bubble); next state LU_STALL; LoadStall_Cnt +1.
REQ-023 No event: PCWr=1, IF_ID_Wr=1, all flushes 0.
REQ-024 States: RUN=0, LU_STALL=1, BR_FLUSH=2; code 3 unused and SHALL return to RUN next cycle.
REQ-025 LU_STALL and BR_FLUSH SHALL each last exactly one unfrozen cycle, then RUN; LU detection suppressed in both; branch/jump still honoured.
REQ-026 Counters SHALL saturate at 16'hFFFF, never wrap; Cnt_Clr=1 clears all to 0 and wins over same-cycle increment.
REQ-027 Only one of LoadStall_Cnt/Flush_Cnt/Freeze_Cnt SHALL increment per cycle, per REQ-018 priority.

Reset
REQ-028 rst=1 SHALL immediately force state RUN (HazState=0) and all counters to 0, independent of clk.
REQ-029 During rst=1, combinational outputs SHALL equal the RUN/no-event values evaluated per REQ-018 on current inputs.
REQ-030 rst asserted mid-LU_STALL or BR_FLUSH SHALL abandon it; first cycle after release is RUN.

Structure
REQ-031 State encodings and counter width (16) SHALL live in the shared pipeline package alongside ALU source-select codes.
REQ-032 One sub-module sat_counter_16 (clk, rst, clr, inc, q) SHALL be instantiated three times.
REQ-033 No other sub-modules; FSM and hazard compare logic in hazard_detect_unit.

Verification
REQ-034 lw $2 in ID/EX, add $3,$2,$4 in IF/ID -> PCWr=0, IF_ID_Wr=0, ID_EX_Flush=1 one cycle; HazState 0->1->0; LoadStall_Cnt=1.
REQ-035 lw $0 target with Rs_IF_ID=0, or lw $5 with UsesRt=0 and Rt=5 -> no stall, all flushes 0.
REQ-036 BranchTaken=1 coincident with LU -> three flushes=1, PCWr=1, HazState->2, Flush_Cnt=1, LoadStall_Cnt=0.
REQ-037 Stall_Req held 3 cycles during LU -> outputs frozen, Freeze_Cnt=3, after release stall proceeds, LoadStall_Cnt=1.
REQ-038 Force LoadStall_Cnt to 16'hFFFE, two LU events -> 16'hFFFF held; Cnt_Clr -> 0; rst in LU_STALL -> HazState=0 without clock edge.
